// File: rtl/int_to_float.sv
`timescale 1ns/1ps
`default_nettype none
// -------------------------------------------------------------------------
// int_to_float : multi-cycle int32 -> IEEE-754 single converter, rev 1.0
// -------------------------------------------------------------------------
module int_to_float (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_a,
  input  logic        in_a_req,
  output logic        in_a_ack,
  output logic [31:0] out_z,
  output logic        out_z_req,
  input  logic        out_z_ack
);

  typedef enum logic [2:0] {
    WAIT_INPUT = 3'd0,
    CONVERT    = 3'd1,
    NORMALISE  = 3'd2,
    ROUND      = 3'd3,
    DRIVE_Z    = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_mant;
  logic [31:0] r_z;
  logic [7:0]  r_exp;
  logic        r_sign;

  logic [31:0] w_abs;
  logic        w_guard;
  logic        w_round;
  logic        w_sticky;
  logic        w_round_up;
  logic        w_carry;
  logic [22:0] w_frac;
  logic [7:0]  w_biased;

  // Two's-complement negate also maps 0x80000000 onto magnitude 0x80000000.
  assign w_abs      = r_a[31] ? (~r_a + 32'd1) : r_a;

  assign w_guard    = r_mant[7];
  assign w_round    = r_mant[6];
  assign w_sticky   = |r_mant[5:0];
  assign w_round_up = w_guard & (w_round | w_sticky | r_mant[8]);

  // The hidden bit is always set here, so an all-ones fraction that rounds up
  // wraps to zero in 23 bits and the carry moves into the exponent.
  assign w_carry    = w_round_up & (&r_mant[30:8]);
  assign w_frac     = w_round_up ? (r_mant[30:8] + 23'd1) : r_mant[30:8];
  assign w_biased   = r_exp + 8'd127 + {7'd0, w_carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= WAIT_INPUT;
      in_a_ack  <= 1'b0;
      out_z_req <= 1'b0;
      out_z     <= 32'd0;
      r_z       <= 32'd0;
      r_a       <= 32'd0;
      r_mant    <= 32'd0;
      r_exp     <= 8'd0;
      r_sign    <= 1'b0;
    end else begin
      case (r_state)
        WAIT_INPUT: begin
          if (!in_a_ack) begin
            in_a_ack <= 1'b1;
          end else if (in_a_req) begin
            r_a      <= in_a;
            in_a_ack <= 1'b0;
            r_state  <= CONVERT;
          end
        end

        CONVERT: begin
          in_a_ack <= 1'b0;
          if (r_a == 32'd0) begin
            r_z     <= 32'd0;
            r_state <= DRIVE_Z;
          end else begin
            r_sign  <= r_a[31];
            r_mant  <= w_abs;
            r_exp   <= 8'd31;
            r_state <= NORMALISE;
          end
        end

        NORMALISE: begin
          in_a_ack <= 1'b0;
          if (r_mant[31]) begin
            r_state <= ROUND;
          end else begin
            r_mant <= r_mant << 1;
            r_exp  <= r_exp - 8'd1;
          end
        end

        ROUND: begin
          in_a_ack <= 1'b0;
          r_z      <= {r_sign, w_biased, w_frac};
          r_state  <= DRIVE_Z;
        end

        DRIVE_Z: begin
          in_a_ack <= 1'b0;
          out_z    <= r_z;
          if (!out_z_req) begin
            out_z_req <= 1'b1;
          end else if (out_z_ack) begin
            out_z_req <= 1'b0;
            r_state   <= WAIT_INPUT;
          end
        end

        default: begin
          in_a_ack  <= 1'b0;
          out_z_req <= 1'b0;
          r_state   <= WAIT_INPUT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
